// File: rtl/mw_cla_add_seq.sv
// Multi-word sequential adder: streams 16-bit slices of wide operands through a
// single cla_adder16, least-significant slice first, chaining the carry in a register.

module cla_adder16 (
    output logic [15:0] sum,
    output logic        carry_out,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in
);
    logic [15:0] p, g, c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;

    // Two-level lookahead: 4-bit group generate/propagate, then group carries.
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gg = '0;
        gp = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = carry_in;
        gc[1] = gg[0] | (gp[0] & carry_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & carry_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & carry_in);
        gc[4] = gg[3] | (gp[3] & gc[3]);
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++)
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
        end
        sum       = p ^ c;
        carry_out = gc[4];
    end
endmodule

module mw_cla_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                carry_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] sum,
    output logic                carry_out,
    output logic                ovf,
    output logic                busy
);
    localparam int         W    = 16 * WORDS;
    localparam logic [3:0] LAST = 4'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_q, b_q, sum_q;
    logic           cy_q, cout_q, ovf_q;
    logic [3:0]     idx;
    logic [15:0]    cla_sum;
    logic           cla_cout;

    cla_adder16 u_cla (
        .sum       (cla_sum),
        .carry_out (cla_cout),
        .a         (a_q[16*idx +: 16]),
        .b         (b_q[16*idx +: 16]),
        .carry_in  (cy_q)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (idx == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Operand capture needs no reset: it is only read after an accept edge.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            cy_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cy_q <= carry_in;
                        idx  <= '0;
                    end
                end
                RUN: begin
                    sum_q[16*idx +: 16] <= cla_sum;
                    cy_q                <= cla_cout;
                    idx                 <= idx + 4'd1;
                    if (idx == LAST) begin
                        cout_q <= cla_cout;
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (cla_sum[15] != a_q[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_mw_cla_add_seq.sv
// Directed bench for mw_cla_add_seq: a 4-word and a 1-word instance side by side.

module tb_mw_cla_add_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
    logic [63:0] a4 = '0, b4 = '0, sum4;
    logic        cin4 = 1'b0, cout4, ovf4, busy4;

    logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0, sum1;
    logic        cin1 = 1'b0, cout1, ovf1, busy1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mw_cla_add_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .carry_in(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .carry_out(cout4), .ovf(ovf4), .busy(busy4)
    );

    mw_cla_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .carry_in(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .carry_out(cout1), .ovf(ovf1), .busy(busy1)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called with dut4 in IDLE, just after an edge.
    task automatic op4(input string tag, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic [63:0] es, input logic ec, input logic eo);
        a4 = av; b4 = bv; cin4 = ci; in_valid4 = 1'b1; out_ready4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        a4 = {$urandom(), $urandom()};
        b4 = {$urandom(), $urandom()};
        cin4 = ~ci;
        check1({tag, "_busy"}, busy4, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 3) check1({tag, "_early_valid"}, out_valid4, 1'b0);
        end
        check1({tag, "_latency_valid"}, out_valid4, 1'b1);
        checkw({tag, "_sum"}, sum4, es);
        check1({tag, "_cout"}, cout4, ec);
        check1({tag, "_ovf"}, ovf4, eo);
        step();
        check1({tag, "_idle_ready"}, in_ready4, 1'b1);
        check1({tag, "_idle_valid"}, out_valid4, 1'b0);
    endtask

    task automatic op1(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic [15:0] es, input logic ec, input logic eo);
        a1 = av; b1 = bv; cin1 = ci; in_valid1 = 1'b1; out_ready1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        a1 = 16'($urandom());
        b1 = 16'($urandom());
        check1({tag, "_run_valid"}, out_valid1, 1'b0);
        step();
        check1({tag, "_latency_valid"}, out_valid1, 1'b1);
        checkw({tag, "_sum"}, {48'd0, sum1}, {48'd0, es});
        check1({tag, "_cout"}, cout1, ec);
        check1({tag, "_ovf"}, ovf1, eo);
        step();
        check1({tag, "_idle_ready"}, in_ready1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check1("rst_in_ready", in_ready4, 1'b1);
        check1("rst_out_valid", out_valid4, 1'b0);
        check1("rst_busy", busy4, 1'b0);
        checkw("rst_sum", sum4, 64'd0);
        check1("rst_cout", cout4, 1'b0);
        check1("rst_ovf", ovf4, 1'b0);
        rst_n = 1'b1;
        step();

        // Basic arithmetic and boundary carries / overflows
        op4("small", 64'd10, 64'd22, 1'b0, 64'd32, 1'b0, 1'b0);
        op4("chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        op4("posovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        op4("negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
            64'd0, 1'b1, 1'b1);
        op4("mixed", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
            64'h1234_5678_9ABC_DF00, 1'b0, 1'b0);
        op4("minus1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);

        // Backpressure: result held while a new operand is pending
        a4 = 64'd1; b4 = 64'd2; cin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
        step();
        a4 = 64'd100; b4 = 64'd200;
        repeat (4) step();
        check1("bp_valid_rise", out_valid4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            checkw("bp_sum_held", sum4, 64'd3);
            check1("bp_in_ready", in_ready4, 1'b0);
            check1("bp_out_valid", out_valid4, 1'b1);
        end
        out_ready4 = 1'b1;
        step();
        check1("bp_release_idle", in_ready4, 1'b1);
        check1("bp_release_valid", out_valid4, 1'b0);
        step();
        check1("bp_new_accept", busy4, 1'b1);
        in_valid4 = 1'b0;
        repeat (4) step();
        check1("bp_new_valid", out_valid4, 1'b1);
        checkw("bp_new_sum", sum4, 64'd300);
        step();

        // Reset abort two cycles into RUN
        a4 = 64'd123; b4 = 64'd456; cin4 = 1'b0; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check1("abort_in_ready", in_ready4, 1'b1);
        check1("abort_out_valid", out_valid4, 1'b0);
        checkw("abort_sum", sum4, 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        op4("after_abort", 64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0);

        // Single-word instance
        op1("w1_ovf", 16'd32768, 16'd65535, 1'b0, 16'd32767, 1'b1, 1'b1);
        op1("w1_max", 16'd65535, 16'd65535, 1'b0, 16'd65534, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
